midi_message_parser: RTL and testbench

//   Consumes bytes from the MIDI UART byte receiver and assembles complete channel-voice messages.

---
 rtl/midi_message_parser.sv | 137 +++++++++++++
 tb/tb_midi_message_parser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: assembles channel-voice messages into note and pitch-bend events.
// Define MIDI_RUNNING_STATUS_EN to let data bytes in IDLE reuse the last channel-voice status.
module midi_message_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byteInput,
    input  logic        byteInputReady,
    output logic        noteEvent,
    output logic        noteGate,
    output logic [6:0]  noteNumber,
    output logic [6:0]  noteVelocity,
    output logic [3:0]  noteChannel,
    output logic        bendEvent,
    output logic [13:0] pitchBend
);

`ifdef MIDI_RUNNING_STATUS_EN
    localparam logic RunningStatusEn = 1'b1;
`else
    localparam logic RunningStatusEn = 1'b0;
`endif

    // Status byte bits [6:4]: 8n..En map to 0..6
    localparam logic [2:0] TypeNoteOff = 3'd0;
    localparam logic [2:0] TypeNoteOn  = 3'd1;
    localparam logic [2:0] TypeProgram = 3'd4;
    localparam logic [2:0] TypePressure = 3'd5;
    localparam logic [2:0] TypeBend    = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        DATA1,
        DATA2,
        SYSEX
    } state_t;

    state_t      state, stateNext;
    logic        readyPrev;
    logic        statusValid, statusValidNext;
    logic [2:0]  msgType, msgTypeNext;
    logic [3:0]  msgChan, msgChanNext;
    logic [6:0]  data1, data1Next;
    logic        fireNote, fireBend, gateNext, takeFirst;
    logic        newByte, isRealTime, isChannelStatus, isSystemCommon;
    logic        oneByteType, accept;

    assign newByte         = byteInputReady && !readyPrev;
    assign isRealTime      = (byteInput[7:3] == 5'b11111);
    assign isChannelStatus = byteInput[7] && (byteInput[7:4] != 4'hF);
    assign isSystemCommon  = (byteInput[7:4] == 4'hF);
    assign oneByteType     = (msgType == TypeProgram) || (msgType == TypePressure);
    assign accept          = OMNI || (msgChan == CHANNEL);
    assign gateNext        = (msgType == TypeNoteOn) && (byteInput[6:0] != 7'd0);

    always_comb begin
        stateNext       = state;
        statusValidNext = statusValid;
        msgTypeNext     = msgType;
        msgChanNext     = msgChan;
        data1Next       = data1;
        fireNote        = 1'b0;
        fireBend        = 1'b0;
        takeFirst       = 1'b0;
        // Real-time bytes may interleave anywhere and must leave all state untouched
        if (newByte && !isRealTime) begin
            if (isChannelStatus) begin
                statusValidNext = 1'b1;
                msgTypeNext     = byteInput[6:4];
                msgChanNext     = byteInput[3:0];
                stateNext       = DATA1;
            end else if (byteInput == 8'hF0) begin
                stateNext = SYSEX;
            end else if (isSystemCommon) begin
                statusValidNext = 1'b0;
                stateNext       = IDLE;
            end else begin
                unique case (state)
                    IDLE:  takeFirst = statusValid && RunningStatusEn;
                    DATA1: takeFirst = 1'b1;
                    DATA2: begin
                        stateNext = IDLE;
                        if (accept) begin
                            fireNote = (msgType == TypeNoteOff) || (msgType == TypeNoteOn);
                            fireBend = (msgType == TypeBend);
                        end
                    end
                    default: ;
                endcase
                if (takeFirst) begin
                    data1Next = byteInput[6:0];
                    stateNext = oneByteType ? IDLE : DATA2;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            readyPrev    <= 1'b1;
            statusValid  <= 1'b0;
            msgType      <= '0;
            msgChan      <= '0;
            data1        <= '0;
            noteEvent    <= 1'b0;
            bendEvent    <= 1'b0;
            noteGate     <= 1'b0;
            noteNumber   <= '0;
            noteVelocity <= '0;
            noteChannel  <= '0;
            pitchBend    <= 14'h2000;
        end else begin
            state       <= stateNext;
            readyPrev   <= byteInputReady;
            statusValid <= statusValidNext;
            msgType     <= msgTypeNext;
            msgChan     <= msgChanNext;
            data1       <= data1Next;
            noteEvent   <= fireNote;
            bendEvent   <= fireBend;
            if (fireNote) begin
                noteGate     <= gateNext;
                noteNumber   <= data1;
                noteVelocity <= byteInput[6:0];
                noteChannel  <= msgChan;
            end
            if (fireBend) begin
                pitchBend   <= {byteInput[6:0], data1};
                noteChannel <= msgChan;
            end
        end
    end

endmodule

// File: tb/tb_midi_message_parser.sv
// Scoreboard bench: two parsers (omni, and channel 2 only) share one byte stream.
module tb_midi_message_parser;

    typedef struct packed {
        logic        isBend;
        logic        gate;
        logic [6:0]  num;
        logic [6:0]  vel;
        logic [3:0]  ch;
        logic [13:0] pb;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byteInput = 8'h00;
    logic        byteInputReady = 1'b0;

    logic        neA, ngA, beA, neB, ngB, beB;
    logic [6:0]  nnA, nvA, nnB, nvB;
    logic [3:0]  ncA, ncB;
    logic [13:0] pbA, pbB;

    ev_t qA[$];
    ev_t qB[$];
    int  errors = 0;
    int  checks = 0;
    logic resetCheck = 1'b0;
    logic done = 1'b0;

    always #10 clock = ~clock;

    midi_message_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dutA (
        .clock(clock), .reset(reset), .byteInput(byteInput), .byteInputReady(byteInputReady),
        .noteEvent(neA), .noteGate(ngA), .noteNumber(nnA), .noteVelocity(nvA),
        .noteChannel(ncA), .bendEvent(beA), .pitchBend(pbA));

    midi_message_parser #(.CHANNEL(4'd2), .OMNI(1'b0)) dutB (
        .clock(clock), .reset(reset), .byteInput(byteInput), .byteInputReady(byteInputReady),
        .noteEvent(neB), .noteGate(ngB), .noteNumber(nnB), .noteVelocity(nvB),
        .noteChannel(ncB), .bendEvent(beB), .pitchBend(pbB));

    task automatic checkEvent(input string name, input logic ne, input logic be, input logic g,
                              input logic [6:0] n, input logic [6:0] v, input logic [3:0] c,
                              input logic [13:0] p, input logic isA);
        ev_t e;
        logic ok;
        checks++;
        if (ne && be) begin
            errors++;
            $display("FAIL %s both_strobes: noteEvent=1 bendEvent=1, required at most one", name);
        end else if ((isA && qA.size() == 0) || (!isA && qB.size() == 0)) begin
            errors++;
            $display("FAIL %s unexpected_event: got bend=%0b gate=%0b num=%0d vel=%0d ch=%0d pb=%h, required none",
                     name, be, g, n, v, c, p);
        end else begin
            e = isA ? qA.pop_front() : qB.pop_front();
            ok = (e.isBend == be) && (e.ch == c) &&
                 (be ? (e.pb == p) : (e.gate == g && e.num == n && e.vel == v));
            if (!ok) begin
                errors++;
                $display("FAIL %s event: got bend=%0b gate=%0b num=%0d vel=%0d ch=%0d pb=%h, required bend=%0b gate=%0b num=%0d vel=%0d ch=%0d pb=%h",
                         name, be, g, n, v, c, p, e.isBend, e.gate, e.num, e.vel, e.ch, e.pb);
            end
        end
    endtask

    task automatic checkReset(input string name, input logic [36:0] got);
        checks++;
        if (got != {1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0, 14'h2000}) begin
            errors++;
            $display("FAIL %s reset_state: got {ne,be,gate,num,vel,ch,pb}=%h, required %h",
                     name, got, {1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 4'd0, 14'h2000});
        end
    endtask

    // Single monitor process owns all counters
    always @(negedge clock) begin
        if (!reset && (neA || beA)) checkEvent("dutA", neA, beA, ngA, nnA, nvA, ncA, pbA, 1'b1);
        if (!reset && (neB || beB)) checkEvent("dutB", neB, beB, ngB, nnB, nvB, ncB, pbB, 1'b0);
        if (resetCheck) begin
            checkReset("dutA", {neA, beA, ngA, nnA, nvA, ncA, pbA});
            checkReset("dutB", {neB, beB, ngB, nnB, nvB, ncB, pbB});
        end
        if (done) begin
            checks++;
            if (qA.size() != 0 || qB.size() != 0) begin
                errors++;
                $display("FAIL missing_events: pending dutA=%0d dutB=%0d, required 0 0", qA.size(), qB.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        byteInput = b;
        byteInputReady = 1'b1;
        tick();
        tick();
        byteInputReady = 1'b0;
        tick();
        tick();
    endtask

    task automatic sendBytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) sendByte(bytes[i]);
    endtask

    function automatic ev_t note(input logic g, input logic [6:0] n, input logic [6:0] v, input logic [3:0] c);
        return '{isBend: 1'b0, gate: g, num: n, vel: v, ch: c, pb: 14'h0};
    endfunction

    function automatic ev_t bend(input logic [13:0] p, input logic [3:0] c);
        return '{isBend: 1'b1, gate: 1'b0, num: 7'd0, vel: 7'd0, ch: c, pb: p};
    endfunction

    task automatic pulseResetCheck();
        resetCheck = 1'b1;
        tick();
        resetCheck = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) tick();
        reset = 1'b0;
        tick();
        pulseResetCheck();

        qA.push_back(note(1'b1, 7'd60, 7'd100, 4'd0));
        sendBytes('{8'h90, 8'h3C, 8'h64});

        qA.push_back(note(1'b0, 7'd64, 7'd0, 4'd3));
        sendBytes('{8'h93, 8'h40, 8'h00});

        qA.push_back(note(1'b1, 7'd60, 7'd64, 4'd1));
        sendBytes('{8'h91, 8'h3C, 8'hF8, 8'h40});

        qA.push_back(bend(14'h3000, 4'd0));
        sendBytes('{8'hE0, 8'h00, 8'h60});

        qA.push_back(note(1'b1, 7'd60, 7'd64, 4'd1));
        sendBytes('{8'h91, 8'h3C, 8'h40});
        qA.push_back(note(1'b1, 7'd60, 7'd64, 4'd2));
        qB.push_back(note(1'b1, 7'd60, 7'd64, 4'd2));
        sendBytes('{8'h92, 8'h3C, 8'h40});
        sendBytes('{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h90});

        qA.push_back(note(1'b1, 7'd60, 7'd64, 4'd0));
`ifdef MIDI_RUNNING_STATUS_EN
        qA.push_back(note(1'b1, 7'd62, 7'd64, 4'd0));
`endif
        sendBytes('{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40});

        // Bend, then a system-common byte clears running status
        qA.push_back(bend(14'h2810, 4'd2));
        qB.push_back(bend(14'h2810, 4'd2));
        sendBytes('{8'hE2, 8'h10, 8'h50, 8'hF6, 8'h11, 8'h22});

        // Status byte mid-message aborts the first one
        qA.push_back(note(1'b1, 7'd61, 7'd127, 4'd2));
        qB.push_back(note(1'b1, 7'd61, 7'd127, 4'd2));
        sendBytes('{8'h90, 8'h3C, 8'h92, 8'h3D, 8'h7F});

        qA.push_back(note(1'b0, 7'd61, 7'd16, 4'd2));
        qB.push_back(note(1'b0, 7'd61, 7'd16, 4'd2));
        sendBytes('{8'h82, 8'h3D, 8'h10});

        sendBytes('{8'hB0, 8'h07, 8'h64, 8'hC2, 8'h05, 8'h06});

        // Reset in the middle of a message
        sendBytes('{8'h90, 8'h3C});
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        pulseResetCheck();
        sendByte(8'h40);

        // A level already high across reset release is not a new byte
        reset = 1'b1;
        byteInput = 8'h90;
        byteInputReady = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        byteInputReady = 1'b0;
        repeat (2) tick();
        sendBytes('{8'h3C, 8'h40});

        repeat (4) tick();
        done = 1'b1;
        tick();
    end

endmodule
